// File: rtl/pong_pkg.sv
// Shared types and constants for the pong score sequencer.
package pong_pkg;

    localparam int TALLY_W   = 7;
    localparam int SCORE_CAP = 99;

    typedef enum logic [2:0] {
        NEWGAME,
        WAIT_SERVE,
        PLAY,
        POINT,
        GAMEOVER
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// One-bit registered rising-edge pulser; history resets high so a level that is
// already asserted when reset releases does not produce an edge.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);

    logic hist_q;
    logic rise_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 1'b1;
            rise_q <= 1'b0;
        end else begin
            hist_q <= sig_i;
            rise_q <= sig_i & ~hist_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/pong_score_fsm.sv
// Pong rally/score sequencer: serve, point scoring, post-point hold and game end.
// Define PONG_WIN_BY_TWO_EN to require a two-point lead for the win.
//
// state      | meaning
// NEWGAME    | clear tallies, pulse d_clr for one cycle
// WAIT_SERVE | ball parked at centre, waiting for a serve press
// PLAY       | ball moving, watching for a miss
// POINT      | ball held for POINT_DELAY cycles, or jump to GAMEOVER on a win
// GAMEOVER   | winner shown, serve press starts a new game
module pong_score_fsm
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 11,
    parameter int POINT_DELAY = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic miss_a,
    input  logic miss_b,
    input  logic btn_serve,
    output logic d_inc_A,
    output logic d_inc_B,
    output logic d_clr,
    output logic ball_run,
    output logic ball_reset,
    output logic serve_side,
    output logic game_over,
    output logic winner
);

    localparam int CNT_W = $clog2(POINT_DELAY + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(POINT_DELAY - 1);
    localparam logic [TALLY_W-1:0] WIN_T    = TALLY_W'(WIN_SCORE);
    localparam logic [TALLY_W-1:0] CAP_T    = TALLY_W'(SCORE_CAP);

    logic miss_a_rise, miss_b_rise, serve_rise;

    rise_detect u_rise_miss_a (.clk(clk), .reset(reset), .sig_i(miss_a),    .rise_o(miss_a_rise));
    rise_detect u_rise_miss_b (.clk(clk), .reset(reset), .sig_i(miss_b),    .rise_o(miss_b_rise));
    rise_detect u_rise_serve  (.clk(clk), .reset(reset), .sig_i(btn_serve), .rise_o(serve_rise));

    state_t             state_q, state_d;
    logic [TALLY_W-1:0] tally_a_q, tally_a_d;
    logic [TALLY_W-1:0] tally_b_q, tally_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic inc_a_q, inc_a_d;
    logic inc_b_q, inc_b_d;
    logic clr_q, clr_d;
    logic run_q, run_d;
    logic breset_q, breset_d;
    logic side_q, side_d;
    logic over_q, over_d;
    logic winner_q, winner_d;

    logic a_wins, b_wins;

`ifdef PONG_WIN_BY_TWO_EN
    assign a_wins = (tally_a_q == CAP_T) ||
                    ((tally_a_q >= WIN_T) && (tally_a_q >= tally_b_q + TALLY_W'(2)));
    assign b_wins = (tally_b_q == CAP_T) ||
                    ((tally_b_q >= WIN_T) && (tally_b_q >= tally_a_q + TALLY_W'(2)));
`else
    assign a_wins = (tally_a_q == CAP_T) || (tally_a_q == WIN_T);
    assign b_wins = (tally_b_q == CAP_T) || (tally_b_q == WIN_T);
`endif

    always_comb begin
        state_d   = state_q;
        tally_a_d = tally_a_q;
        tally_b_d = tally_b_q;
        cnt_d     = cnt_q;
        inc_a_d   = 1'b0;
        inc_b_d   = 1'b0;
        clr_d     = 1'b0;
        side_d    = side_q;
        winner_d  = winner_q;

        case (state_q)
            NEWGAME: begin
                clr_d     = 1'b1;
                tally_a_d = '0;
                tally_b_d = '0;
                side_d    = 1'b0;
                winner_d  = 1'b0;
                state_d   = WAIT_SERVE;
            end
            WAIT_SERVE: begin
                if (serve_rise) state_d = PLAY;
            end
            PLAY: begin
                // miss_a takes priority when both walls are crossed together
                if (miss_a_rise) begin
                    tally_b_d = tally_b_q + TALLY_W'(1);
                    inc_b_d   = 1'b1;
                    side_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = POINT;
                end else if (miss_b_rise) begin
                    tally_a_d = tally_a_q + TALLY_W'(1);
                    inc_a_d   = 1'b1;
                    side_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = POINT;
                end
            end
            POINT: begin
                if (a_wins) begin
                    winner_d = 1'b0;
                    state_d  = GAMEOVER;
                end else if (b_wins) begin
                    winner_d = 1'b1;
                    state_d  = GAMEOVER;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = WAIT_SERVE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAMEOVER: begin
                if (serve_rise) state_d = NEWGAME;
            end
            default: state_d = NEWGAME;
        endcase

        // Level outputs follow the state being entered so they line up with state_q.
        run_d    = (state_d == PLAY);
        breset_d = (state_d != PLAY);
        over_d   = (state_d == GAMEOVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= NEWGAME;
            tally_a_q <= '0;
            tally_b_q <= '0;
            cnt_q     <= '0;
            inc_a_q   <= 1'b0;
            inc_b_q   <= 1'b0;
            clr_q     <= 1'b0;
            run_q     <= 1'b0;
            breset_q  <= 1'b1;
            side_q    <= 1'b0;
            over_q    <= 1'b0;
            winner_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tally_a_q <= tally_a_d;
            tally_b_q <= tally_b_d;
            cnt_q     <= cnt_d;
            inc_a_q   <= inc_a_d;
            inc_b_q   <= inc_b_d;
            clr_q     <= clr_d;
            run_q     <= run_d;
            breset_q  <= breset_d;
            side_q    <= side_d;
            over_q    <= over_d;
            winner_q  <= winner_d;
        end
    end

    assign d_inc_A    = inc_a_q;
    assign d_inc_B    = inc_b_q;
    assign d_clr      = clr_q;
    assign ball_run   = run_q;
    assign ball_reset = breset_q;
    assign serve_side = side_q;
    assign game_over  = over_q;
    assign winner     = winner_q;

endmodule
